// File: rtl/par2ser_multi.sv
// Parallel-to-serial width converter: takes one block of RATIO words and offers
// them one word per transfer, with lane index and last-word flag, MSW or LSW first.
module par2ser_multi #(
  parameter int DWIDTH     = 16,
  parameter int RATIO      = 2,
  parameter int RATIO_LOG  = 1,
  parameter int WORD_ORDER = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       in_req,
  input  logic                       in_ack,
  input  logic [DWIDTH*RATIO-1:0]    in_data,
  output logic                       out_req,
  input  logic                       out_ack,
  output logic [DWIDTH-1:0]          out_data,
  output logic [RATIO_LOG-1:0]       out_idx,
  output logic                       out_last
);

  localparam int BW = DWIDTH * RATIO;
  localparam logic [RATIO_LOG-1:0] LAST_IDX = RATIO_LOG'(RATIO - 1);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [RATIO_LOG-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]          buf_q, buf_d;
  logic [DWIDTH-1:0]      data_d;
  logic [RATIO_LOG-1:0]   idx_d;
  logic                   last_d;
  logic                   in_req_d, out_req_d;
  logic                   in_xfer, out_xfer;

  // Word 0 of the block is the most-significant slice; WORD_ORDER=1 walks from the bottom.
  function automatic logic [DWIDTH-1:0] word_sel(input logic [BW-1:0] blk, input int k);
    int pos;
    pos = (WORD_ORDER == 0) ? k : (RATIO - 1 - k);
    return blk[(RATIO - 1 - pos) * DWIDTH +: DWIDTH];
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    data_d   = out_data;
    idx_d    = out_idx;
    last_d   = out_last;
    in_xfer  = in_req && in_ack;
    out_xfer = out_req && out_ack;

    case (state_q)
      S_FILL: begin
        if (in_xfer) begin
          buf_d   = in_data;
          cnt_d   = '0;
          data_d  = word_sel(in_data, 0);
          idx_d   = '0;
          last_d  = (LAST_IDX == '0);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_xfer) begin
          if (cnt_q == LAST_IDX) begin
            state_d = S_FILL;
          end else begin
            cnt_d  = cnt_q + RATIO_LOG'(1);
            data_d = word_sel(buf_q, int'(cnt_q) + 1);
            idx_d  = cnt_q + RATIO_LOG'(1);
            last_d = ((cnt_q + RATIO_LOG'(1)) == LAST_IDX);
          end
        end
      end
      default: state_d = S_FILL;
    endcase

    // Handshake outputs follow the next state so they come straight out of flops.
    in_req_d  = (state_d == S_FILL);
    out_req_d = (state_d == S_DRAIN);
  end

  // Reset releases in FILL with in_req low; in_req rises one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FILL;
      cnt_q    <= '0;
      buf_q    <= '0;
      in_req   <= 1'b0;
      out_req  <= 1'b0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      in_req   <= in_req_d;
      out_req  <= out_req_d;
      out_data <= data_d;
      out_idx  <= idx_d;
      out_last <= last_d;
    end
  end

endmodule

// File: tb/tb_par2ser_multi.sv
// Bench for par2ser_multi: three configurations, scoreboard queues checked on each output transfer.
module tb_par2ser_multi;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: 16x2 MSW first
  logic        in_req_a, in_ack_a = 1'b0, out_req_a, out_ack_a = 1'b0, out_last_a;
  logic [31:0] in_data_a = '0;
  logic [15:0] out_data_a;
  logic [0:0]  out_idx_a;
  // B: 16x2 LSW first
  logic        in_req_b, in_ack_b = 1'b0, out_req_b, out_ack_b = 1'b0, out_last_b;
  logic [31:0] in_data_b = '0;
  logic [15:0] out_data_b;
  logic [0:0]  out_idx_b;
  // C: 8x4 MSW first
  logic        in_req_c, in_ack_c = 1'b0, out_req_c, out_ack_c = 1'b0, out_last_c;
  logic [31:0] in_data_c = '0;
  logic [7:0]  out_data_c;
  logic [1:0]  out_idx_c;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int   xq_a[$];

  par2ser_multi #(.DWIDTH(16), .RATIO(2), .RATIO_LOG(1), .WORD_ORDER(0)) dut_a (
    .clk(clk), .rst(rst), .in_req(in_req_a), .in_ack(in_ack_a), .in_data(in_data_a),
    .out_req(out_req_a), .out_ack(out_ack_a), .out_data(out_data_a),
    .out_idx(out_idx_a), .out_last(out_last_a));

  par2ser_multi #(.DWIDTH(16), .RATIO(2), .RATIO_LOG(1), .WORD_ORDER(1)) dut_b (
    .clk(clk), .rst(rst), .in_req(in_req_b), .in_ack(in_ack_b), .in_data(in_data_b),
    .out_req(out_req_b), .out_ack(out_ack_b), .out_data(out_data_b),
    .out_idx(out_idx_b), .out_last(out_last_b));

  par2ser_multi #(.DWIDTH(8), .RATIO(4), .RATIO_LOG(2), .WORD_ORDER(0)) dut_c (
    .clk(clk), .rst(rst), .in_req(in_req_c), .in_ack(in_ack_c), .in_data(in_data_c),
    .out_req(out_req_c), .out_ack(out_ack_c), .out_data(out_data_c),
    .out_idx(out_idx_c), .out_last(out_last_c));

  // Scoreboard monitors: a word is consumed on the edge following a negedge with req && ack.
  always @(negedge clk) begin
    if (!rst && out_req_a && out_ack_a) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_word: got %h idx %0d last %b, expected no word", out_data_a, out_idx_a, out_last_a);
      end else begin
        ea = qa.pop_front();
        if (out_data_a !== ea.d || out_idx_a !== ea.idx[0:0] || out_last_a !== ea.last) begin
          errors++;
          $display("FAIL a_word: got %h/%0d/%b, expected %h/%0d/%b", out_data_a, out_idx_a, out_last_a, ea.d, ea.idx, ea.last);
        end
      end
    end
    if (!rst && in_req_a && in_ack_a) xq_a.push_back(cyc + 1);
  end

  always @(negedge clk) begin
    if (!rst && out_req_b && out_ack_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_word: got %h idx %0d, expected no word", out_data_b, out_idx_b);
      end else begin
        eb = qb.pop_front();
        if (out_data_b !== eb.d || out_idx_b !== eb.idx[0:0] || out_last_b !== eb.last) begin
          errors++;
          $display("FAIL b_word: got %h/%0d/%b, expected %h/%0d/%b", out_data_b, out_idx_b, out_last_b, eb.d, eb.idx, eb.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_req_c && out_ack_c) begin
      checks++;
      if (qc.size() == 0) begin
        errors++;
        $display("FAIL c_unexpected_word: got %h idx %0d, expected no word", out_data_c, out_idx_c);
      end else begin
        ec = qc.pop_front();
        if (out_data_c !== ec.d[7:0] || out_idx_c !== ec.idx[1:0] || out_last_c !== ec.last) begin
          errors++;
          $display("FAIL c_word: got %h/%0d/%b, expected %h/%0d/%b", out_data_c, out_idx_c, out_last_c, ec.d[7:0], ec.idx, ec.last);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_req_a, out_req_a, out_data_a, out_idx_a, out_last_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: got %b, expected all zero", {in_req_a, out_req_a, out_data_a, out_idx_a, out_last_a});
    end
    checks++;
    if ({in_req_b, out_req_b, out_data_b, out_idx_b, out_last_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got %b, expected all zero", {in_req_b, out_req_b, out_data_b, out_idx_b, out_last_b});
    end
    checks++;
    if ({in_req_c, out_req_c, out_data_c, out_idx_c, out_last_c} !== '0) begin
      errors++;
      $display("FAIL reset_c: got %b, expected all zero", {in_req_c, out_req_c, out_data_c, out_idx_c, out_last_c});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_req_a !== 1'b0) begin
      errors++;
      $display("FAIL in_req_early: got %b, expected 0", in_req_a);
    end
    @(negedge clk);
    checks++;
    if ({in_req_a, in_req_b, in_req_c} !== 3'b111) begin
      errors++;
      $display("FAIL in_req_rise: got %b, expected 111", {in_req_a, in_req_b, in_req_c});
    end
  endtask

  task automatic test_msw_first();
    for (int i = 0; i < 20 && in_req_a !== 1'b1; i++) @(negedge clk);
    checks++;
    if (in_req_a !== 1'b1) begin
      errors++;
      $display("FAIL msw_wait_in_req: got %b, expected 1", in_req_a);
    end
    @(posedge clk); #1;
    in_data_a = 32'h1234ABCD; in_ack_a = 1'b1; out_ack_a = 1'b1;
    qa.push_back('{16'h1234, 8'd0, 1'b0});
    qa.push_back('{16'hABCD, 8'd1, 1'b1});
    @(posedge clk); #1 in_ack_a = 1'b0;
    @(negedge clk);
    checks++;
    if (out_req_a !== 1'b1 || in_req_a !== 1'b0 || out_data_a !== 16'h1234) begin
      errors++;
      $display("FAIL msw_latency: got req %b/%b data %h, expected 1/0 1234", out_req_a, in_req_a, out_data_a);
    end
    @(negedge clk);
    checks++;
    if (in_req_a !== 1'b0) begin
      errors++;
      $display("FAIL msw_in_req_k1: got %b, expected 0", in_req_a);
    end
    @(negedge clk);
    checks++;
    if (in_req_a !== 1'b1 || qa.size() != 0) begin
      errors++;
      $display("FAIL msw_in_req_k2: got in_req %b pending %0d, expected 1 and 0", in_req_a, qa.size());
    end
    out_ack_a = 1'b0;
  endtask

  task automatic test_lsw_first();
    for (int i = 0; i < 20 && in_req_b !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1;
    in_data_b = 32'h1234ABCD; in_ack_b = 1'b1; out_ack_b = 1'b1;
    qb.push_back('{16'hABCD, 8'd0, 1'b0});
    qb.push_back('{16'h1234, 8'd1, 1'b1});
    @(posedge clk); #1 in_ack_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ack_b = 1'b0;
    @(negedge clk);
    checks++;
    if (qb.size() != 0 || in_req_b !== 1'b1) begin
      errors++;
      $display("FAIL lsw_done: got pending %0d in_req %b, expected 0 and 1", qb.size(), in_req_b);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 20 && in_req_c !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1;
    in_data_c = 32'h01020304; in_ack_c = 1'b1; out_ack_c = 1'b1;
    for (int k = 0; k < 4; k++) qc.push_back('{16'(k + 1), 8'(k), (k == 3)});
    @(posedge clk); #1 in_ack_c = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 out_ack_c = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if (out_req_c !== 1'b1 || out_data_c !== 8'h03 || out_idx_c !== 2'd2 || out_last_c !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got req %b data %h idx %0d last %b, expected 1 03 2 0", out_req_c, out_data_c, out_idx_c, out_last_c);
      end
    end
    @(posedge clk); #1 out_ack_c = 1'b1;
    repeat (3) @(posedge clk);
    #1 out_ack_c = 1'b0;
    @(negedge clk);
    checks++;
    if (qc.size() != 0 || in_req_c !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got pending %0d in_req %b, expected 0 and 1", qc.size(), in_req_c);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20 && in_req_a !== 1'b1; i++) @(negedge clk);
    xq_a.delete();
    @(posedge clk); #1;
    in_data_a = 32'h00010002; in_ack_a = 1'b1; out_ack_a = 1'b1;
    qa.push_back('{16'h0001, 8'd0, 1'b0});
    qa.push_back('{16'h0002, 8'd1, 1'b1});
    qa.push_back('{16'h0003, 8'd0, 1'b0});
    qa.push_back('{16'h0004, 8'd1, 1'b1});
    @(posedge clk); #1 in_data_a = 32'h00030004;
    repeat (3) @(posedge clk);
    #1 in_ack_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ack_a = 1'b0;
    @(negedge clk);
    checks++;
    if (xq_a.size() != 2) begin
      errors++;
      $display("FAIL b2b_block_count: got %0d, expected 2", xq_a.size());
    end else begin
      checks++;
      if (xq_a[1] - xq_a[0] != 3) begin
        errors++;
        $display("FAIL b2b_period: got %0d cycles, expected 3", xq_a[1] - xq_a[0]);
      end
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending: got %0d, expected 0", qa.size());
    end
  endtask

  task automatic test_reset_mid_block();
    for (int i = 0; i < 20 && in_req_a !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1;
    in_data_a = 32'hDEADBEEF; in_ack_a = 1'b1; out_ack_a = 1'b1;
    qa.push_back('{16'hDEAD, 8'd0, 1'b0});
    @(posedge clk); #1 in_ack_a = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_req_a, out_req_a, out_data_a, out_idx_a, out_last_a} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got %b, expected all zero", {in_req_a, out_req_a, out_data_a, out_idx_a, out_last_a});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_req_a !== 1'b1 || out_req_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_req: got in_req %b out_req %b, expected 1 0", in_req_a, out_req_a);
    end
    @(posedge clk); #1;
    in_data_a = 32'h5555AAAA; in_ack_a = 1'b1;
    qa.push_back('{16'h5555, 8'd0, 1'b0});
    qa.push_back('{16'hAAAA, 8'd1, 1'b1});
    @(posedge clk); #1 in_ack_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ack_a = 1'b0;
    @(negedge clk);
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL midrst_pending: got %0d, expected 0", qa.size());
    end
  endtask

  task automatic test_spurious();
    for (int i = 0; i < 20 && in_req_a !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1 out_ack_a = 1'b1;
    @(posedge clk); #1 out_ack_a = 1'b0;
    @(negedge clk);
    checks++;
    if (in_req_a !== 1'b1 || out_req_a !== 1'b0) begin
      errors++;
      $display("FAIL spur_out_ack: got in_req %b out_req %b, expected 1 0", in_req_a, out_req_a);
    end
    @(posedge clk); #1;
    in_data_a = 32'h11112222; in_ack_a = 1'b1;
    qa.push_back('{16'h1111, 8'd0, 1'b0});
    qa.push_back('{16'h2222, 8'd1, 1'b1});
    @(posedge clk); #1;
    in_data_a = 32'hFFFFFFFF;
    @(posedge clk); #1 in_ack_a = 1'b0;
    @(negedge clk);
    checks++;
    if (out_req_a !== 1'b1 || in_req_a !== 1'b0 || out_data_a !== 16'h1111 || out_idx_a !== 1'b0) begin
      errors++;
      $display("FAIL spur_in_ack: got req %b/%b data %h idx %0d, expected 1/0 1111 0", out_req_a, in_req_a, out_data_a, out_idx_a);
    end
    @(posedge clk); #1 out_ack_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ack_a = 1'b0;
    @(negedge clk);
    checks++;
    if (qa.size() != 0 || in_req_a !== 1'b1) begin
      errors++;
      $display("FAIL spur_done: got pending %0d in_req %b, expected 0 and 1", qa.size(), in_req_a);
    end
  endtask

  initial begin
    test_reset();
    test_msw_first();
    test_lsw_first();
    test_stall();
    test_back_to_back();
    test_reset_mid_block();
    test_spurious();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
